// File: rtl/ram_stream_pkg.sv
// Shared types and width helpers for the RAM read streamer.
package ram_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit width needed to index 'value' entries, never less than 1.
    function automatic int clog2_safe(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Bit width of a counter that must hold 0..max_value inclusive.
    function automatic int count_width(input int max_value);
        return clog2_safe(max_value + 1);
    endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Register-based show-ahead FIFO; an incoming word is visible the same cycle
// when the FIFO is empty, so the RAM read latency is not lengthened.
module ram_rd_skid_fifo
    import ram_stream_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 33,
    parameter int COUNT_WIDTH = count_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   valid,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int PW = clog2_safe(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   empty;
    logic                   do_rd;
    logic                   bypass_rd;
    logic                   stored_rd;
    logic                   do_wr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        valid     = !empty || wr_en;
        rd_data   = (empty && wr_en) ? wr_data : mem_q[rd_ptr_q];
        do_rd     = rd_en && valid;
        // A word read straight through while empty is never stored.
        bypass_rd = empty && do_rd;
        stored_rd = do_rd && !empty;
        do_wr     = wr_en && !bypass_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (stored_rd) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_q + COUNT_WIDTH'(do_wr) - COUNT_WIDTH'(stored_rd);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ram_rd_streamer.sv
// Burst read sequencer for a pipelined RAM port, presenting read data as a
// valid/ready stream with a last flag.
//   state | meaning
//   IDLE  | waiting for a burst command; len=0 commands only pulse done
//   RUN   | issuing reads and draining the output FIFO until last word pops
module ram_rd_streamer
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2,
    parameter int LEN_WIDTH   = ADDR_WIDTH + 1,
    parameter int FIFO_DEPTH  = PIPE_STAGES + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_re_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);

    localparam int IW = count_width(PIPE_STAGES);
    localparam int CW = count_width(FIFO_DEPTH);

    state_t                 state_q;
    state_t                 state_d;
    logic                   done_q;
    logic                   done_d;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic [LEN_WIDTH-1:0]   issued_q;
    logic [IW-1:0]          inflight_q;
    logic [PIPE_STAGES-1:0] tag_v_q;
    logic [PIPE_STAGES-1:0] tag_l_q;

    logic                   accept;
    logic                   empty_cmd;
    logic                   credit_ok;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   fifo_valid;
    logic [DATA_WIDTH:0]    fifo_rd;
    logic [CW-1:0]          fifo_count;

    assign accept    = (state_q == IDLE) && start_i && (len_i != '0);
    assign empty_cmd = (state_q == IDLE) && start_i && (len_i == '0);
    // Every word in flight already owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
    assign issue     = (state_q == RUN) && (remaining_q != '0) && credit_ok;
    // The RAM output register only advances with re, so keep re high until
    // every tagged read has reached the output.
    assign ram_re_o  = issue || (inflight_q != '0);
    assign ram_a_o   = ADDR_WIDTH'(LEN_WIDTH'(base_q) + issued_q);
    assign push      = ram_re_o && tag_v_q[PIPE_STAGES-1];
    assign pop       = fifo_valid && m_ready_i;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
                if (empty_cmd) begin
                    done_d = 1'b1;
                end
            end
            RUN: begin
                if (pop && fifo_rd[DATA_WIDTH]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            base_q      <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            inflight_q  <= '0;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (accept) begin
                base_q      <= base_i;
                remaining_q <= len_i;
                issued_q    <= '0;
            end else if (issue) begin
                remaining_q <= remaining_q - LEN_WIDTH'(1);
                issued_q    <= issued_q + LEN_WIDTH'(1);
            end

            if (ram_re_o) begin
                for (int i = PIPE_STAGES - 1; i > 0; i--) begin
                    tag_v_q[i] <= tag_v_q[i-1];
                    tag_l_q[i] <= tag_l_q[i-1];
                end
                tag_v_q[0] <= issue;
                tag_l_q[0] <= issue && (remaining_q == LEN_WIDTH'(1));
            end

            inflight_q <= inflight_q + IW'(issue) - IW'(push);
        end
    end

    ram_rd_skid_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (push),
        .wr_data ({tag_l_q[PIPE_STAGES-1], ram_rd_i}),
        .rd_en   (m_ready_i),
        .rd_data (fifo_rd),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign busy_o    = (state_q == RUN);
    assign done_o    = done_q;
    assign m_data_o  = fifo_rd[DATA_WIDTH-1:0];
    assign m_valid_o = fifo_valid;
    assign m_last_o  = fifo_valid && fifo_rd[DATA_WIDTH];

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Bench for ram_rd_streamer with a 2-stage RAM model preloaded mem[i] = i*3.
module tb_ram_rd_streamer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  base_i;
    logic [8:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  ram_a_o;
    logic        ram_re_o;
    logic [31:0] ram_rd_i;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ram_rd_streamer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .base_i    (base_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ram_a_o   (ram_a_o),
        .ram_re_o  (ram_re_o),
        .ram_rd_i  (ram_rd_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .m_ready_i (m_ready_i)
    );

    // RAM port B: two read stages, both advancing only on re.
    logic [31:0] ram_mem [256];
    logic [31:0] ram_s1 = '0;
    logic [31:0] ram_s2 = '0;

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'(i) * 32'd3;
    end

    always @(posedge clk_i) begin
        if (ram_re_o) begin
            ram_s1 <= ram_mem[ram_a_o];
            ram_s2 <= ram_s1;
        end
    end

    assign ram_rd_i = ram_s2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] b, input int idx);
        logic [7:0] a;
        a = b + 8'(idx);
        return {24'd0, a} * 32'd3;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at a negedge. mode: 0 ready high, 1 ready 1-of-3, 2 random.
    // abort_after != 0 returns right after that many words were accepted.
    // poke pulses a conflicting start while the burst is busy.
    task automatic run_burst(input logic [7:0] b, input logic [8:0] l, input int mode,
                             input int abort_after, input bit poke);
        int          npop;
        int          first_c;
        int          last_c;
        int          ln;
        int          cyc;
        logic        pv;
        logic        pr;
        logic [31:0] pd;
        npop = 0; first_c = -1; last_c = -1; ln = int'(l);
        pv = 1'b0; pr = 1'b0; pd = '0;
        start_i = 1'b1; base_i = b; len_i = l; m_ready_i = 1'b1;
        @(negedge clk_i);
        cyc = 1;
        while (cyc <= 600 && npop < ln) begin
            if (poke && cyc == 2) begin
                start_i = 1'b1; base_i = b + 8'h40; len_i = 9'd3;
            end else begin
                start_i = 1'b0;
            end
            m_ready_i = ready_for(mode, cyc);
            check_eq("busy_run", 64'(busy_o), 64'd1);
            check_eq("done_run", 64'(done_o), 64'd0);
            if (pv && !pr) begin
                check_eq("stall_valid", 64'(m_valid_o), 64'd1);
                check_eq("stall_data", 64'(m_data_o), 64'(pd));
            end
            if (m_valid_o) begin
                if (first_c < 0) first_c = cyc;
                if (m_ready_i) begin
                    check_eq("data", 64'(m_data_o), 64'(exp_word(b, npop)));
                    check_eq("last", 64'(m_last_o), 64'(npop == ln - 1));
                    npop++;
                    last_c = cyc;
                end
            end
            pv = m_valid_o; pr = m_ready_i; pd = m_data_o;
            if (abort_after != 0 && npop == abort_after) begin
                @(negedge clk_i);
                return;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        check_eq("word_count", 64'(npop), 64'(ln));
        if (mode == 0) begin
            check_eq("first_valid_cyc", 64'(first_c), 64'd3);
            check_eq("last_cyc", 64'(last_c), 64'(ln + 2));
        end
        check_eq("done_pulse", 64'(done_o), 64'd1);
        check_eq("busy_end", 64'(busy_o), 64'd0);
        check_eq("no_stale_valid", 64'(m_valid_o), 64'd0);
        @(negedge clk_i);
        check_eq("done_clear", 64'(done_o), 64'd0);
        check_eq("re_idle", 64'(ram_re_o), 64'd0);
        check_eq("valid_idle", 64'(m_valid_o), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_done"}, 64'(done_o), 64'd0);
        check_eq({tag, "_re"}, 64'(ram_re_o), 64'd0);
        check_eq({tag, "_valid"}, 64'(m_valid_o), 64'd0);
        check_eq({tag, "_last"}, 64'(m_last_o), 64'd0);
        check_eq({tag, "_addr"}, 64'(ram_a_o), 64'd0);
        check_eq({tag, "_data"}, 64'(m_data_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0; m_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        run_burst(8'h10, 9'd8, 0, 0, 1'b0);
        run_burst(8'hFE, 9'd4, 0, 0, 1'b0);
        run_burst(8'h40, 9'd16, 1, 0, 1'b0);

        start_i = 1'b1; base_i = 8'h05; len_i = 9'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("empty_done", 64'(done_o), 64'd1);
        check_eq("empty_busy", 64'(busy_o), 64'd0);
        check_eq("empty_re", 64'(ram_re_o), 64'd0);
        @(negedge clk_i);
        check_eq("empty_done_clear", 64'(done_o), 64'd0);
        check_eq("empty_busy2", 64'(busy_o), 64'd0);
        check_eq("empty_re2", 64'(ram_re_o), 64'd0);

        run_burst(8'h80, 9'd6, 0, 0, 1'b1);

        run_burst(8'h20, 9'd10, 0, 3, 1'b0);
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        run_burst(8'h00, 9'd2, 0, 0, 1'b0);

        run_burst(8'hF0, 9'd5, 2, 0, 1'b0);
        run_burst(8'h33, 9'd3, 0, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_burst(8'($urandom_range(0, 255)), 9'($urandom_range(1, 40)), 2, 0, 1'b0);
        end
        run_burst(8'hFF, 9'd256, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
